// File: rtl/fetch_wb_sequencer.sv
// fetch_wb_sequencer: multi-cycle control sequencer for the fetch/register-file datapath.
// Steps each instruction through FETCH, MEMWAIT, DECODE, EXEC and WRITEBACK, owns the PC
// and a retired-instruction counter, and provides run / single-step / halt control.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   run                  level; continuous execution while high
//   step                 run exactly one instruction (honoured only in IDLE)
//   halt_req             stop once the current instruction retires
//   wb_req, wb_dest      register write request and destination, sampled in WRITEBACK
//   branch_taken/target  redirect the PC at WRITEBACK (target forced word-aligned)
//   pc, fetch_addr       architectural PC; instruction-memory address (same value)
//   fetch_en             instruction-memory read strobe (FETCH)
//   ir_load              instruction-register load strobe (DECODE)
//   rg_wrt_en            register-file write enable (WRITEBACK)
//   busy, halted         not-IDLE / IDLE status
//   retired_count        wrapping count of retired instructions
module fetch_wb_sequencer #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned PC_STEP  = 4,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned MEM_LAT  = 1   // legal range 1..3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            step,
  input  logic            halt_req,
  input  logic            wb_req,
  input  logic [4:0]      wb_dest,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] fetch_addr,
  output logic            fetch_en,
  output logic            ir_load,
  output logic            rg_wrt_en,
  output logic            busy,
  output logic            halted,
  output logic [15:0]     retired_count
);

  localparam int unsigned CNT_W = 2;
  localparam int unsigned RC_W  = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    MEMWAIT   = 3'd2,
    DECODE    = 3'd3,
    EXEC      = 3'd4,
    WRITEBACK = 3'd5
  } state_t;

  state_t            state, state_next;
  logic              step_mode, step_mode_next;
  logic              halt_pending, halt_pending_next;
  logic [CNT_W-1:0]  lat_cnt, lat_cnt_next;
  logic              fetch_en_next, ir_load_next, busy_next, halted_next;
  logic              retire;
  logic [PC_W-1:0]   pc_next;
  logic [PC_W-1:0]   branch_aligned;

  // Branch targets are forced onto a word boundary.
  assign branch_aligned = branch_target & ~PC_W'(3);
  assign pc_next        = branch_taken ? branch_aligned : pc + PC_W'(PC_STEP);
  assign fetch_addr     = pc;

  // Next-state and strobe decode.
  always_comb begin
    state_next        = state;
    step_mode_next    = step_mode;
    halt_pending_next = halt_pending;
    lat_cnt_next      = lat_cnt;
    rg_wrt_en         = 1'b0;
    retire            = 1'b0;

    if (state != IDLE && halt_req) halt_pending_next = 1'b1;

    case (state)
      IDLE: begin
        if (run) begin
          state_next     = FETCH;
          step_mode_next = 1'b0;
        end else if (step) begin
          state_next     = FETCH;
          step_mode_next = 1'b1;
        end
      end
      FETCH: begin
        lat_cnt_next = CNT_W'(MEM_LAT - 1);
        state_next   = MEMWAIT;
      end
      MEMWAIT: begin
        if (lat_cnt == '0) state_next = DECODE;
        else               lat_cnt_next = lat_cnt - CNT_W'(1);
      end
      DECODE: state_next = EXEC;
      EXEC:   state_next = WRITEBACK;
      WRITEBACK: begin
        // Write enable must coincide with the WRITEBACK cycle itself, so it is decoded
        // from the live request rather than registered. x0 is never written.
        rg_wrt_en = wb_req && (wb_dest != 5'd0);
        retire    = 1'b1;
        // A halt request arriving in WRITEBACK also stops after this instruction.
        if (run && !halt_pending && !halt_req && !step_mode) state_next = FETCH;
        else                                                 state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (state_next == IDLE) halt_pending_next = 1'b0;

    // Strobes/status are registered from the next state so they align with it.
    fetch_en_next = (state_next == FETCH);
    ir_load_next  = (state_next == DECODE);
    busy_next     = (state_next != IDLE);
    halted_next   = (state_next == IDLE);
  end

  // State, control flags and registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      step_mode    <= 1'b0;
      halt_pending <= 1'b0;
      lat_cnt      <= '0;
      fetch_en     <= 1'b0;
      ir_load      <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b1;
    end else begin
      state        <= state_next;
      step_mode    <= step_mode_next;
      halt_pending <= halt_pending_next;
      lat_cnt      <= lat_cnt_next;
      fetch_en     <= fetch_en_next;
      ir_load      <= ir_load_next;
      busy         <= busy_next;
      halted       <= halted_next;
    end
  end

  // PC and retired counter advance together when an instruction retires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc            <= PC_W'(RESET_PC);
      retired_count <= '0;
    end else if (retire) begin
      pc            <= pc_next;
      retired_count <= retired_count + RC_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_wb_sequencer.sv
// Testbench for fetch_wb_sequencer: scoreboard of expected fetches (address, retired count)
// and register writes (PC of the writing instruction), plus cycle-exact strobe checks.
// A second instance with MEM_LAT=3 shares the stimulus for the latency check.
module tb_fetch_wb_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run, step, halt_req, wb_req, branch_taken;
  logic [4:0] wb_dest;
  logic [7:0] branch_target;

  logic [7:0]  pc, fetch_addr;
  logic        fetch_en, ir_load, rg_wrt_en, busy, halted;
  logic [15:0] retired_count;

  logic [7:0]  pc_l3, fetch_addr_l3;
  logic        fetch_en_l3, ir_load_l3, rg_wrt_en_l3, busy_l3, halted_l3;
  logic [15:0] retired_count_l3;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] ret;
  } fexp_t;

  fexp_t      fq[$];
  logic [7:0] wq[$];

  always #5 clk = ~clk;

  fetch_wb_sequencer #(.PC_W(8), .PC_STEP(4), .RESET_PC(0), .MEM_LAT(1)) u_dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
    .wb_req(wb_req), .wb_dest(wb_dest), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc(pc), .fetch_addr(fetch_addr),
    .fetch_en(fetch_en), .ir_load(ir_load), .rg_wrt_en(rg_wrt_en), .busy(busy),
    .halted(halted), .retired_count(retired_count)
  );

  fetch_wb_sequencer #(.PC_W(8), .PC_STEP(4), .RESET_PC(0), .MEM_LAT(3)) u_dut_lat3 (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
    .wb_req(wb_req), .wb_dest(wb_dest), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc(pc_l3), .fetch_addr(fetch_addr_l3),
    .fetch_en(fetch_en_l3), .ir_load(ir_load_l3), .rg_wrt_en(rg_wrt_en_l3),
    .busy(busy_l3), .halted(halted_l3), .retired_count(retired_count_l3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; sample point is the falling edge.
  task automatic wait_cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int which, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if ((which == 0) ? halted : halted_l3) break;
      wait_cyc();
    end
    check(which == 0 ? "idle_timeout" : "idle_timeout_l3",
          32'((which == 0) ? halted : halted_l3), 32'd1);
  endtask

  // Scoreboard monitor for the MEM_LAT=1 instance.
  always @(negedge clk) begin
    if (reset) begin
      if (fetch_en) begin
        if (fq.size() == 0) check("fetch_unexpected", 32'd1, 32'd0);
        else begin
          fexp_t e;
          e = fq.pop_front();
          check("fetch_addr", 32'(fetch_addr), 32'(e.pc));
          check("fetch_retired", 32'(retired_count), 32'(e.ret));
        end
      end
      if (rg_wrt_en) begin
        if (wq.size() == 0) check("wrt_unexpected", 32'd1, 32'd0);
        else begin
          logic [7:0] wpc;
          wpc = wq.pop_front();
          check("wrt_pc", 32'(pc), 32'(wpc));
        end
      end
      check("strobe_excl", 32'(fetch_en + ir_load + rg_wrt_en <= 2'd1), 32'd1);
    end
  end

  initial begin
    reset = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0; wb_req = 1'b0;
    wb_dest = 5'd0; branch_taken = 1'b0; branch_target = 8'h00;

    // Reset state
    wait_cyc();
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_retired", 32'(retired_count), 32'd0);
    check("rst_fetch_en", 32'(fetch_en), 32'd0);
    #1 reset = 1'b1;
    wait_cyc();
    check("idle_after_rst", 32'(halted), 32'd1);

    // Continuous run: fetch every 5 cycles
    fq.push_back('{8'h00, 16'd0});
    fq.push_back('{8'h04, 16'd1});
    fq.push_back('{8'h08, 16'd2});
    #1 run = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      wait_cyc();
      check("run_fetch_en", 32'(fetch_en), 32'(k == 1 || k == 6 || k == 11));
      if (k == 11) begin
        check("run_pc", 32'(pc), 32'h08);
        check("run_retired", 32'(retired_count), 32'd2);
        #1 run = 1'b0;
      end
    end
    wait_idle(0, 10);
    check("run_pc_end", 32'(pc), 32'h0C);

    // Single step with register write; second step while busy ignored
    fq.push_back('{8'h0C, 16'd3});
    wq.push_back(8'h0C);
    #1 begin step = 1'b1; wb_req = 1'b1; wb_dest = 5'd5; end
    for (int k = 1; k <= 6; k++) begin
      wait_cyc();
      if (k == 1) check("step_busy", 32'(busy), 32'd1);
      check("step_wrt", 32'(rg_wrt_en), 32'(k == 5));
      if (k == 1) #1 step = 1'b0;
      if (k == 2) #1 step = 1'b1;
      if (k == 3) #1 step = 1'b0;
    end
    check("step_halted", 32'(halted), 32'd1);
    check("step_pc", 32'(pc), 32'h10);
    check("step_retired", 32'(retired_count), 32'd4);
    for (int k = 0; k < 3; k++) wait_cyc();
    check("step_stays_idle", 32'(halted), 32'd1);
    check("step_no_replay", 32'(retired_count), 32'd4);

    // Writes to x0 suppressed
    fq.push_back('{8'h10, 16'd4});
    fq.push_back('{8'h14, 16'd5});
    #1 begin run = 1'b1; wb_req = 1'b1; wb_dest = 5'd0; end
    for (int k = 1; k <= 10; k++) begin
      wait_cyc();
      check("x0_no_wrt", 32'(rg_wrt_en), 32'd0);
      if (k == 6) #1 run = 1'b0;
    end
    wait_idle(0, 5);
    check("x0_pc", 32'(pc), 32'h18);
    check("x0_retired", 32'(retired_count), 32'd6);

    // Branch alignment then PC wrap 0xFC -> 0x00
    fq.push_back('{8'h18, 16'd6});
    fq.push_back('{8'h20, 16'd7});
    fq.push_back('{8'hFC, 16'd8});
    #1 begin run = 1'b1; wb_req = 1'b0; branch_taken = 1'b1; branch_target = 8'h23; end
    for (int k = 1; k <= 11; k++) begin
      wait_cyc();
      if (k == 6) begin
        check("br_pc", 32'(pc), 32'h20);
        #1 branch_target = 8'hFF;
      end
      if (k == 11) #1 begin branch_taken = 1'b0; run = 1'b0; end
    end
    wait_idle(0, 10);
    check("wrap_pc", 32'(pc), 32'h00);
    check("wrap_retired", 32'(retired_count), 32'd9);

    // Halt during MEMWAIT with run held
    fq.push_back('{8'h00, 16'd9});
    fq.push_back('{8'h04, 16'd10});
    #1 run = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      wait_cyc();
      if (k == 2) #1 halt_req = 1'b1;
      if (k == 3) #1 halt_req = 1'b0;
      if (k == 6) check("halt_idle", 32'(halted), 32'd1);
      if (k == 7) begin
        check("halt_refetch", 32'(fetch_en), 32'd1);
        #1 run = 1'b0;
      end
    end
    wait_idle(0, 10);
    check("halt_pc", 32'(pc), 32'h08);
    check("halt_retired", 32'(retired_count), 32'd11);

    // Reset during DECODE with a pending write
    fq.push_back('{8'h08, 16'd11});
    #1 begin run = 1'b1; wb_req = 1'b1; wb_dest = 5'd3; end
    for (int k = 1; k <= 3; k++) wait_cyc();
    check("decode_ir_load", 32'(ir_load), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("arst_halted", 32'(halted), 32'd1);
    check("arst_pc", 32'(pc), 32'h00);
    check("arst_retired", 32'(retired_count), 32'd0);
    check("arst_no_wrt", 32'(rg_wrt_en), 32'd0);
    run = 1'b0; wb_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_cyc();
      check("arst_hold_wrt", 32'(rg_wrt_en), 32'd0);
    end
    #1 reset = 1'b1;
    wait_cyc();

    // MEM_LAT=3: 7-cycle instruction latency
    fq.push_back('{8'h00, 16'd0});
    fq.push_back('{8'h04, 16'd1});
    #1 run = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      wait_cyc();
      check("lat3_fetch_en", 32'(fetch_en_l3), 32'(k == 1 || k == 8));
      check("lat3_ir_load", 32'(ir_load_l3), 32'(k == 5));
      if (k == 8) #1 run = 1'b0;
    end
    wait_idle(0, 10);
    wait_idle(1, 15);
    check("lat3_pc", 32'(pc_l3), 32'h08);
    check("lat3_retired", 32'(retired_count_l3), 32'd2);
    check("lat1_pc", 32'(pc), 32'h08);

    check("fetch_q_empty", 32'(fq.size()), 32'd0);
    check("wrt_q_empty", 32'(wq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_wb_sequencer.md
# fetch_wb_sequencer

Multi-cycle control sequencer for the fetch/register-file datapath: the PC register, the +4 PC adder, the instruction memory and the two-read/one-write register file. It steps each instruction through FETCH, MEMWAIT, DECODE, EXEC and WRITEBACK. It drives the instruction-memory address and enable, the instruction-register load and the register-file write enable, and updates the PC once per instruction. It also provides run, single-step and halt control, plus a retired-instruction counter for debug.

## Interface
- PC_W, 8, PC / instruction-address width
- PC_STEP, 4, sequential PC increment
- RESET_PC, 0, PC value after reset
- MEM_LAT, 1, instruction-memory read latency in cycles; legal range 1..3
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- run  in  1  level; continuous execution while high
- step  in  1  execute exactly one instruction; honoured only in IDLE
- halt_req  in  1  stop after the current instruction retires
- wb_req  in  1  decoded instruction writes a register; sampled in WRITEBACK
- wb_dest  in  5  destination register index; sampled in WRITEBACK
- branch_taken  in  1  take branch_target at WRITEBACK
- branch_target  in  PC_W  next PC when branch_taken=1
- pc  out  PC_W  architectural PC register
- fetch_addr  out  PC_W  instruction-memory address; equals pc
- fetch_en  out  1  instruction-memory read strobe
- ir_load  out  1  latch instruction word into the IR
- rg_wrt_en  out  1  register-file write enable
- busy  out  1  high in any state other than IDLE
- halted  out  1  high in IDLE
- retired_count  out  16  instructions retired; wraps

## Operation
- States: IDLE, FETCH, MEMWAIT, DECODE, EXEC, WRITEBACK.
- IDLE transitions:
  - run=1 -> FETCH, with step_mode=0.
  - else step=1 -> FETCH, with step_mode=1.
  - run has priority over step.
- FETCH: fetch_en=1 for exactly one cycle, then MEMWAIT.
- MEMWAIT: stays for MEM_LAT cycles, counted by an internal down-counter loaded in FETCH. Then DECODE.
- DECODE: ir_load=1 for one cycle; register-file reads use the IR fields. Then EXEC.
- EXEC: one cycle for ALU/branch resolution; no strobes. Then WRITEBACK.
- WRITEBACK actions, all in the same cycle:
  - rg_wrt_en = wb_req && (wb_dest != 0). Writes to x0 are suppressed.
  - pc <= branch_taken ? {branch_target[PC_W-1:2], 2'b00} : pc + PC_STEP, modulo 2^PC_W. Wraps 0xFC -> 0x00 for PC_W=8.
  - retired_count <= retired_count + 1, modulo 2^16.
- WRITEBACK exit: -> FETCH if run=1, halt_pending=0 and step_mode=0; otherwise -> IDLE.
- halt_pending:
  - set when halt_req=1 in any non-IDLE state;
  - cleared on entry to IDLE;
  - halt_req in IDLE has no effect.
- run falling mid-instruction: the current instruction completes through WRITEBACK, then IDLE. Instructions are never aborted except by reset.
- step while busy is ignored; it is not queued.
- fetch_en, ir_load and rg_wrt_en are mutually exclusive, and each is high for at most one cycle per instruction.

## Timing
- Reset (reset=0, asynchronous):
  - state=IDLE, pc=RESET_PC, retired_count=0;
  - fetch_en=ir_load=rg_wrt_en=busy=0, halted=1;
  - step_mode=0, halt_pending=0.
- Reset asserted mid-instruction: no register-file write occurs and the PC is not updated.
- Leaving reset: the first transition is on the first rising edge with reset=1.
- Latency per instruction is MEM_LAT+4 cycles, from FETCH entry to WRITEBACK exit. This is 5 cycles for MEM_LAT=1.
- With run held high, fetch_en pulses every MEM_LAT+4 cycles.
- From run rising in IDLE to fetch_en=1: 1 cycle.
- The new pc value is visible in the cycle after WRITEBACK, which is the next FETCH cycle; fetch_addr therefore uses the updated PC.
- retired_count and pc update on the same edge.
- halted and busy are registered-state decodes and are valid every cycle.

## Test plan
- Reset, then run=1 for 12 cycles (MEM_LAT=1) -> fetch_en pulses at cycles 1, 6 and 11 after run; pc goes 0x00 -> 0x04 -> 0x08; retired_count=2 at cycle 11.
- From IDLE, step pulse of 1 cycle with wb_req=1, wb_dest=5 -> a single rg_wrt_en pulse in WRITEBACK (cycle 5), pc=0x04, return to IDLE, halted=1, retired_count=1. A second step issued during busy -> ignored.
- run=1, wb_req=1, wb_dest=0 -> rg_wrt_en stays 0 for every instruction; pc and retired_count still advance.
- run=1, branch_taken=1 and branch_target=0x23 at WRITEBACK -> next pc=0x20. With pc=0xFC and no branch -> next pc=0x00.
- halt_req pulsed during MEMWAIT with run=1 -> instruction completes, then IDLE. No further fetch_en until run is re-sampled in IDLE.
- reset=0 during DECODE with wb_req=1 -> immediate IDLE; no rg_wrt_en pulse, pc=RESET_PC, retired_count=0. Repeat with MEM_LAT=3 -> instruction latency of 7 cycles.
